// File: rtl/adder_tree_seq.sv
// rtl/adder_tree_seq.sv - sequences chunk reads into an adder tree and accumulates the sums.
// Optional macro ADDER_TREE_SEQ_SAT_EN selects saturating instead of wrapping accumulation.
module adder_tree_seq #(
    parameter int TREE_SIZE = 8,
    parameter int LATENCY   = 4,
    parameter int CNT_W     = 6
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_chunks,
    input  logic             i_src_ready,
    output logic             o_rd_en,
    output logic [CNT_W-1:0] o_chunk_idx,
    input  logic [31:0]      i_tree_sum,
    output logic             o_busy,
    output logic [31:0]      o_result,
    output logic             o_result_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    // Lane count only shapes the external tree; an empty block flags a nonsensical value.
    if (TREE_SIZE < 1) begin : g_tree_size_invalid
    end

    state_t             r_state;
    logic [CNT_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_issue_cnt;
    logic [CNT_W-1:0]   r_recv_cnt;
    logic [LATENCY-1:0] r_vsr;
    logic [31:0]        r_acc;
    logic [31:0]        r_result;
    logic               r_result_valid;

    logic               w_rd_en;
    logic               w_tap;
    logic               w_last_issue;
    logic               w_last_recv;
    logic [31:0]        w_acc_next;

    assign w_rd_en      = (r_state == S_ISSUE) && i_src_ready;
    // Taps only count while a job is live, so nothing lingering after reset is summed.
    assign w_tap        = r_vsr[LATENCY-1] && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
    assign w_last_issue = (r_issue_cnt == (r_num - CNT_W'(1)));
    assign w_last_recv  = (r_recv_cnt == (r_num - CNT_W'(1)));

`ifdef ADDER_TREE_SEQ_SAT_EN
    logic [32:0] w_sum_ext;
    assign w_sum_ext  = {r_acc[31], r_acc} + {i_tree_sum[31], i_tree_sum};
    assign w_acc_next = (w_sum_ext[32] != w_sum_ext[31])
                      ? (w_sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                      : w_sum_ext[31:0];
`else
    assign w_acc_next = r_acc + i_tree_sum;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_num          <= '0;
            r_issue_cnt    <= '0;
            r_recv_cnt     <= '0;
            r_vsr          <= '0;
            r_acc          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_vsr          <= (r_vsr << 1) | LATENCY'(w_rd_en);
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num       <= i_num_chunks;
                        r_acc       <= '0;
                        r_issue_cnt <= '0;
                        r_recv_cnt  <= '0;
                        if (i_num_chunks == '0) begin
                            r_state        <= S_DONE;
                            r_result       <= '0;
                            r_result_valid <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE, S_DRAIN: begin
                    if (w_rd_en) begin
                        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                        if (w_last_issue) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    // Completion outranks the ISSUE->DRAIN move when both land together.
                    if (w_tap) begin
                        r_acc      <= w_acc_next;
                        r_recv_cnt <= r_recv_cnt + CNT_W'(1);
                        if (w_last_recv) begin
                            r_state        <= S_DONE;
                            r_result       <= w_acc_next;
                            r_result_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rd_en        = w_rd_en;
    assign o_chunk_idx    = r_issue_cnt;
    assign o_busy         = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;

endmodule
